// File: rtl/vga_linedoubler.sv
// vga_linedoubler: 15 kHz to VGA line doubler; scanline dimming built only with VGA_LINEDOUBLER_SCANLINES_EN
module vga_linedoubler #(
  parameter int CW          = 3,
  parameter int ADDRW       = 10,
  parameter int HSYNC_COUNT = 80,
  parameter int VSYNC_COUNT = 2744
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic          enable_scandoubling,
  input  logic [1:0]    scan_mode,
  input  logic [CW-1:0] ri,
  input  logic [CW-1:0] gi,
  input  logic [CW-1:0] bi,
  input  logic          hsync_ext_n,
  input  logic          vsync_ext_n,
  input  logic          csync_ext_n,
  output logic [CW-1:0] ro,
  output logic [CW-1:0] go,
  output logic [CW-1:0] bo,
  output logic          hsync,
  output logic          vsync,
  output logic          line_ovf
);
  localparam int PW = 3 * CW;
  localparam int VW = $clog2(VSYNC_COUNT + 1);
  localparam logic [ADDRW-1:0] CMAX = '1;
  localparam logic [31:0] HSC = HSYNC_COUNT;

  logic [PW-1:0]    r_mem [2**(ADDRW+1)];
  logic [PW-1:0]    r_rdata;
  logic [ADDRW-1:0] r_wcnt, r_rcnt, r_linelen, r_rcnt_d1;
  logic             r_wbank, r_rbank, r_pass, r_pass_d1, r_valid, r_valid_d1;
  logic             r_hs_prev, r_vs_prev;
  logic [VW-1:0]    r_vcnt;
  logic [CW-1:0]    r_ro, r_go, r_bo;
  logic             r_hsync, r_vsync;
  logic             w_line_end, w_vs_fall;
  logic [CW-1:0]    w_r, w_g, w_b;

  assign w_line_end = pix_en & r_hs_prev & ~hsync_ext_n;
  assign w_vs_fall  = r_vs_prev & ~vsync_ext_n;

  // two-bank line buffer; contents are never reset, read data arrives one clk later
  always_ff @(posedge clk) begin
    if (pix_en) r_mem[{r_wbank, r_wcnt}] <= {ri, gi, bi};
    r_rdata <= r_mem[{r_rbank, r_rcnt}];
  end

  // write side: saturating pixel counter, bank swap on the sampled hsync falling edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_hs_prev <= 1'b1;
      r_wcnt    <= '0;
      r_linelen <= '0;
      r_wbank   <= 1'b0;
      r_valid   <= 1'b0;
      line_ovf  <= 1'b0;
    end else if (pix_en) begin
      r_hs_prev <= hsync_ext_n;
      if (w_line_end) begin
        r_linelen <= r_wcnt;
        r_wbank   <= ~r_wbank;
        r_wcnt    <= '0;
        r_valid   <= 1'b1;
      end else if (r_wcnt != CMAX) r_wcnt <= r_wcnt + 1'b1;
      else line_ovf <= 1'b1;
    end

  // read side: replay the completed line at full clk rate, second and later passes flagged
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rcnt     <= '0;
      r_rbank    <= 1'b0;
      r_pass     <= 1'b0;
      r_rcnt_d1  <= '0;
      r_pass_d1  <= 1'b0;
      r_valid_d1 <= 1'b0;
    end else begin
      r_rcnt_d1  <= r_rcnt;
      r_pass_d1  <= r_pass;
      r_valid_d1 <= r_valid;
      if (w_line_end) begin
        r_rcnt  <= '0;
        r_rbank <= r_wbank;
        r_pass  <= 1'b0;
      end else if (r_rcnt == r_linelen) begin
        r_rcnt <= '0;
        r_pass <= 1'b1;
      end else r_rcnt <= r_rcnt + 1'b1;
    end

`ifdef VGA_LINEDOUBLER_SCANLINES_EN
  function automatic logic [CW-1:0] dim(input logic [CW-1:0] c, input logic [1:0] m, input logic p);
    return !p ? c : m == 2'd1 ? c - (c >> 2) : m == 2'd2 ? c >> 1 : m == 2'd3 ? '0 : c;
  endfunction
  assign w_r = dim(r_rdata[PW-1 -: CW], scan_mode, r_pass_d1);
  assign w_g = dim(r_rdata[2*CW-1 -: CW], scan_mode, r_pass_d1);
  assign w_b = dim(r_rdata[CW-1:0], scan_mode, r_pass_d1);
`else
  logic w_unused;
  assign w_unused = &{1'b0, scan_mode, r_pass_d1};
  assign {w_r, w_g, w_b} = r_rdata;
`endif

  // output stage: colour blanked until a full line exists, hsync from the delayed read count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ro    <= '0;
      r_go    <= '0;
      r_bo    <= '0;
      r_hsync <= 1'b1;
    end else begin
      r_ro    <= r_valid_d1 ? w_r : '0;
      r_go    <= r_valid_d1 ? w_g : '0;
      r_bo    <= r_valid_d1 ? w_b : '0;
      r_hsync <= 32'(r_rcnt_d1) >= HSC;
    end

  // vsync: fixed-width pulse per input falling edge, later edges ignored while it runs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_vs_prev <= 1'b1;
      r_vcnt    <= '0;
      r_vsync   <= 1'b1;
    end else begin
      r_vs_prev <= vsync_ext_n;
      if (r_vcnt != '0) begin
        r_vcnt  <= r_vcnt - 1'b1;
        r_vsync <= r_vcnt == VW'(1);
      end else if (w_vs_fall) begin
        r_vcnt  <= VW'(VSYNC_COUNT);
        r_vsync <= 1'b0;
      end
    end

  assign ro    = enable_scandoubling ? r_ro : ri;
  assign go    = enable_scandoubling ? r_go : gi;
  assign bo    = enable_scandoubling ? r_bo : bi;
  assign hsync = enable_scandoubling ? r_hsync : csync_ext_n;
  assign vsync = enable_scandoubling ? r_vsync : 1'b1;
endmodule

// File: doc/vga_linedoubler.md
VGA_LINEDOUBLER -- requirements
Module: vga_linedoubler

Interface
REQ-001 SHALL have parameter CW, default 3, bits per colour channel.
REQ-002 SHALL have parameter ADDRW, default 10, log2 of maximum input line length; buffer holds 2 x 2^ADDRW words of 3*CW bits.
REQ-003 SHALL have parameter HSYNC_COUNT, default 80, VGA hsync low width in clk cycles.
REQ-004 SHALL have parameter VSYNC_COUNT, default 2744, VGA vsync low width in clk cycles.
REQ-005 SHALL have ports, clock and reset first; clk is the single clock, rst is asynchronous active-high:
clk  in  1  system clock, output pixel rate
rst  in  1  asynchronous reset, active high
pix_en  in  1  input pixel strobe, one clk wide, at most every 2nd cycle
enable_scandoubling  in  1  1 = VGA output, 0 = 15 kHz bypass
scan_mode  in  2  0 none, 1 75 %, 2 50 %, 3 black second pass
ri, gi, bi  in  CW each  input colour
hsync_ext_n, vsync_ext_n, csync_ext_n  in  1 each  input syncs, active low
ro, go, bo  out  CW each  output colour
hsync, vsync  out  1 each  output syncs, active low
line_ovf  out  1  sticky: an input line exceeded 2^ADDRW pixels

Function
REQ-006 Write side SHALL act only on cycles with pix_en=1, writing {ri,gi,bi} to address {wbank, wcnt}.
REQ-007 wcnt SHALL increment per written pixel and saturate at 2^ADDRW-1 (no wrap); reaching saturation while still writing SHALL set line_ovf.
REQ-008 A falling edge of hsync_ext_n sampled on pix_en cycles SHALL load linelen <= wcnt, toggle wbank, clear wcnt; the pixel of that cycle is written to the old bank.
REQ-009 Read side SHALL advance rcnt every clk, reading {rbank, rcnt}.
REQ-010 On the write-side line-end event (REQ-008), in the same cycle, rcnt <= 0, rbank <= the bank just completed, pass <= 0.
REQ-011 When rcnt == linelen and no line-end event occurs that cycle, rcnt <= 0 and pass <= 1; a line-end event SHALL take priority.
REQ-012 With pass=1 and rcnt reaching linelen again, the same line SHALL be replayed with pass held at 1.
REQ-013 Buffer read latency SHALL be 1 clk; colour and hsync outputs SHALL be registered so that rcnt changes appear on ro/go/bo/hsync exactly 2 clk later, mutually aligned.
REQ-014 VGA hsync SHALL be low while the delayed rcnt < HSYNC_COUNT, high otherwise.
REQ-015 Dimming SHALL apply only when pass=1: mode 1 c-(c>>2), mode 2 c>>1, mode 3 0, mode 0 c; computed per channel in CW bits without overflow.
REQ-016 VGA vsync SHALL go low 1 clk after a sampled falling edge of vsync_ext_n and stay low exactly VSYNC_COUNT cycles, even if vsync_ext_n rises earlier; one pulse per low period; re-armed only by vsync_ext_n high.
REQ-017 Until the first line-end event after reset (linelen invalid), VGA colour outputs SHALL be 0.
REQ-018 With enable_scandoubling=0: ro/go/bo = ri/gi/bi, hsync = csync_ext_n, vsync = 1, combinational; internal counters keep running.
REQ-019 Toggling enable_scandoubling SHALL not reset any state.

Reset
REQ-020 rst SHALL asynchronously clear wcnt, rcnt, linelen, wbank, rbank, pass, line_ovf, edge-detect registers (to 1), vsync counter; registered ro/go/bo to 0; registered hsync and vsync to 1.
REQ-021 Buffer contents SHALL not be reset; the first output line after reset is blanked per REQ-017.

Configuration
REQ-022 With macro VGA_LINEDOUBLER_SCANLINES_EN defined, dimming per REQ-015 SHALL be built; without it, scan_mode SHALL be ignored and pass=1 output SHALL equal pass=0 output, with no dimming logic synthesised.

Verification
REQ-023 448 pixels per line (pix_en every 2nd clk), ramp data, scan_mode=0 -> each line output twice from the buffer, 2 clk after rcnt, hsync low 80 clk at each pass start.
REQ-024 Same stimulus, macro defined, scan_mode=1, pixel 7 -> first pass 7, second pass 6; scan_mode=2 -> 3; scan_mode=3 -> 0; macro undefined -> 7 in all cases.
REQ-025 Input line of 1100 pixels with ADDRW=10 -> wcnt stops at 1023, line_ovf=1 and stays 1 until rst.
REQ-026 vsync_ext_n low for 100 clk -> vsync low exactly 2744 clk starting 1 clk after edge; second pulse only after vsync_ext_n returns high then low.
REQ-027 enable_scandoubling=0, csync_ext_n toggling, ri=5 -> ro=5, hsync follows csync_ext_n, vsync=1 same cycle.
REQ-028 rst asserted mid-line -> outputs 0/hsync 1/vsync 1 immediately; after release, first line black, following line doubled correctly.
